// File: rtl/fip_pkg.sv
// Shared Q16.16 fixed-point constants, types and dot3 FSM state for the fip_32 datapath.
package fip_pkg;
  localparam int INT_BITS  = 16;
  localparam int FRAC_BITS = 16;
  localparam int WIDTH     = INT_BITS + FRAC_BITS;
  localparam int PROD_W    = 2 * WIDTH;
  localparam int TERM_W    = 2 * WIDTH - FRAC_BITS;
  localparam int ACC_W     = 2 * WIDTH + 2;

  typedef logic signed [WIDTH-1:0] fip_t;

  localparam fip_t FIP_MAX = 32'sh7FFF_FFFF;
  localparam fip_t FIP_MIN = 32'sh8000_0000;
  localparam fip_t FIP_ONE = 32'sh0001_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } dot3_state_t;
endpackage

// File: rtl/fip_32_dot3_if.sv
// Operand/result handshake bundle for fip_32_dot3 (master = producer/consumer side, slave = dot3 core).
interface fip_32_dot3_if;
  import fip_pkg::*;

  logic in_valid;
  logic in_ready;
  fip_t a_x, a_y, a_z;
  fip_t b_x, b_y, b_z;
  logic out_valid;
  logic out_ready;
  fip_t result;
  logic overflow;

  modport master (
    output in_valid, a_x, a_y, a_z, b_x, b_y, b_z, out_ready,
    input  in_ready, out_valid, result, overflow
  );

  modport slave (
    input  in_valid, a_x, a_y, a_z, b_x, b_y, b_z, out_ready,
    output in_ready, out_valid, result, overflow
  );
endinterface

// File: rtl/fip_32_mul_shift.sv
// Combinational Q16.16 multiply with rescale; FIP_ROUND_EN selects round-half-up instead of truncation.
module fip_32_mul_shift
  import fip_pkg::*;
(
  input  fip_t                     i_a,
  input  fip_t                     i_b,
  output logic signed [TERM_W-1:0] o_term
);
  localparam logic signed [PROD_W-1:0] RND_HALF = PROD_W'(1) << (FRAC_BITS - 1);

  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] w_adj;

  assign w_prod = PROD_W'(i_a) * PROD_W'(i_b);

`ifdef FIP_ROUND_EN
  assign w_adj = w_prod + RND_HALF;
`else
  assign w_adj = w_prod;
`endif

  // The shifted product of two 32-bit operands always fits in TERM_W bits.
  assign o_term = TERM_W'(w_adj >>> FRAC_BITS);
endmodule

// File: rtl/fip_32_dot3.sv
// Sequential Q16.16 3-component dot product: one shared multiplier, wide accumulator, saturated output.
// Optional build macro FIP_ROUND_EN (see fip_32_mul_shift) switches term rounding to round-half-up.
module fip_32_dot3
  import fip_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  fip_32_dot3_if.slave  bus
);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(FIP_MAX);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(FIP_MIN);

  dot3_state_t              r_state;
  logic                     r_in_ready;
  logic                     r_out_valid;
  fip_t                     r_result;
  logic                     r_overflow;
  logic signed [ACC_W-1:0]  r_acc;
  logic [1:0]               r_idx;
  fip_t                     r_ax, r_ay, r_az;
  fip_t                     r_bx, r_by, r_bz;

  fip_t                     w_op_a;
  fip_t                     w_op_b;
  logic signed [TERM_W-1:0] w_term;
  logic signed [ACC_W-1:0]  w_sum;
  logic [WIDTH:0]           w_sat;

  function automatic logic [WIDTH:0] sat_fip(input logic signed [ACC_W-1:0] s);
    if (s > SAT_HI) return {1'b1, FIP_MAX};
    if (s < SAT_LO) return {1'b1, FIP_MIN};
    return {1'b0, fip_t'(s)};
  endfunction

  always_comb begin
    w_op_a = r_ax;
    w_op_b = r_bx;
    case (r_idx)
      2'd1: begin w_op_a = r_ay; w_op_b = r_by; end
      2'd2: begin w_op_a = r_az; w_op_b = r_bz; end
      default: begin end
    endcase
  end

  fip_32_mul_shift u_mul (
    .i_a    (w_op_a),
    .i_b    (w_op_b),
    .o_term (w_term)
  );

  assign w_sum = r_acc + ACC_W'(w_term);
  assign w_sat = sat_fip(w_sum);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_overflow  <= 1'b0;
      r_acc       <= '0;
      r_idx       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_ax       <= bus.a_x;
            r_ay       <= bus.a_y;
            r_az       <= bus.a_z;
            r_bx       <= bus.b_x;
            r_by       <= bus.b_y;
            r_bz       <= bus.b_z;
            r_acc      <= '0;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_MUL;
          end
        end
        ST_MUL: begin
          r_acc <= w_sum;
          r_idx <= r_idx + 2'd1;
          // The third term goes straight into the saturated result on the same edge.
          if (r_idx == 2'd2) begin
            r_result    <= fip_t'(w_sat[WIDTH-1:0]);
            r_overflow  <= w_sat[WIDTH];
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_fip_32_dot3.sv
// Directed self-checking bench for fip_32_dot3: cycle-level reference model plus literal expectations.
module tb_fip_32_dot3;
  import fip_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   chk_en = 1'b0;

  fip_32_dot3_if bus();

  fip_32_dot3 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: exact integer arithmetic on the Q16.16 values.
  function automatic longint term_ref(input fip_t a, input fip_t b);
    longint p;
    p = longint'(a) * longint'(b);
`ifdef FIP_ROUND_EN
    p = p + 64'sd32768;
`endif
    return p >>> 16;
  endfunction

  function automatic logic [32:0] dot_ref(input fip_t ax, ay, az, bx, by, bz);
    longint s;
    s = term_ref(ax, bx) + term_ref(ay, by) + term_ref(az, bz);
    if (s > 64'sd2147483647)  return {1'b1, 32'h7FFF_FFFF};
    if (s < -64'sd2147483648) return {1'b1, 32'h8000_0000};
    return {1'b0, s[31:0]};
  endfunction

  // Cycle model: phase 0 idle, 1..3 computing, 4 result presented.
  int          m_phase = 0;
  logic [31:0] m_res = '0;
  logic        m_ovf = 1'b0;
  logic [32:0] m_pend = '0;
  logic [32:0] dut_log[$];

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  {31'd0, bus.in_ready},  {31'd0, m_phase == 0});
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_phase == 4});
      chk("result",    bus.result,             m_res);
      chk("overflow",  {31'd0, bus.overflow},  {31'd0, m_ovf});
    end
    if (reset) begin
      m_phase = 0;
      m_res   = '0;
      m_ovf   = 1'b0;
    end else begin
      case (m_phase)
        0: if (bus.in_valid) begin
             m_pend  = dot_ref(bus.a_x, bus.a_y, bus.a_z, bus.b_x, bus.b_y, bus.b_z);
             m_phase = 1;
           end
        1, 2: m_phase = m_phase + 1;
        3: begin
             m_phase = 4;
             m_res   = m_pend[31:0];
             m_ovf   = m_pend[32];
           end
        default: if (bus.out_ready) begin
             dut_log.push_back({bus.overflow, bus.result});
             m_phase = 0;
           end
      endcase
    end
  end

  int last_acc = 0;

  task automatic send(input fip_t ax, ay, az, bx, by, bz);
    bit ok = 1'b0;
    bus.a_x = ax; bus.a_y = ay; bus.a_z = az;
    bus.b_x = bx; bus.b_y = by; bus.b_z = bz;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    last_acc = cyc;
    chk("accept_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_result(output fip_t r, output logic o, output int lat);
    bit got = 1'b0;
    lat = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.out_valid) got = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    r = bus.result;
    o = bus.overflow;
    chk("result_timeout", {31'd0, got}, 32'd1);
  endtask

  fip_t        r;
  logic        o;
  int          lat;
  int          acc_t[4];
  fip_t        sv[4][6];
  logic [32:0] e;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a_x = '0; bus.a_y = '0; bus.a_z = '0;
    bus.b_x = '0; bus.b_y = '0; bus.b_z = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_result", bus.result, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: basic value and latency
    send(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 32'h0005_0000, 32'h0006_0000);
    wait_result(r, o, lat);
    chk("t1_result", r, 32'h0020_0000);
    chk("t1_ovf", {31'd0, o}, 32'd0);
    chk("t1_latency", lat, 32'd3);

    // 2: saturation both ways
    send(32'h7FFF_0000, 32'h7FFF_0000, 32'h0, 32'h0002_0000, 32'h0002_0000, 32'h0);
    wait_result(r, o, lat);
    chk("sat_pos", r, 32'h7FFF_FFFF);
    chk("sat_pos_ovf", {31'd0, o}, 32'd1);
    send(32'h8001_0000, 32'h8001_0000, 32'h0, 32'h0002_0000, 32'h0002_0000, 32'h0);
    wait_result(r, o, lat);
    chk("sat_neg", r, 32'h8000_0000);
    chk("sat_neg_ovf", {31'd0, o}, 32'd1);

    // 3: backpressure with a competing in_valid
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 32'h0005_0000, 32'h0006_0000);
    wait_result(r, o, lat);
    bus.a_x = 32'h0009_0000; bus.b_x = 32'h0009_0000; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_result", bus.result, 32'h0020_0000);
      chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);

    // 4: rounding of the half-LSB product
    send(32'h0000_0001, 32'h0, 32'h0, 32'h0000_8000, 32'h0, 32'h0);
    wait_result(r, o, lat);
`ifdef FIP_ROUND_EN
    chk("rnd_pos", r, 32'h0000_0001);
`else
    chk("rnd_pos", r, 32'h0000_0000);
`endif
    send(32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0000_8000, 32'h0, 32'h0);
    wait_result(r, o, lat);
`ifdef FIP_ROUND_EN
    chk("rnd_neg", r, 32'h0000_0000);
`else
    chk("rnd_neg", r, 32'hFFFF_FFFF);
`endif

    // 5: reset while multiplying
    @(posedge clk); #1;
    send(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 32'h0005_0000, 32'h0006_0000);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_result", bus.result, 32'h0);
    send(32'h0002_0000, 32'h0, 32'h0, 32'h0000_8000, 32'h0, 32'h0);
    wait_result(r, o, lat);
    chk("midrst_fresh", r, 32'h0001_0000);

    // 6: streaming, back-to-back requests
    @(posedge clk); #1;
    dut_log.delete();
    sv[0] = '{32'h0001_8000, 32'hFFFF_0000, 32'h0000_4000, 32'h0002_0000, 32'h0003_0000, 32'hFFFE_0000};
    sv[1] = '{32'h0010_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_8000, 32'h0001_0000, 32'h0001_0000};
    sv[2] = '{32'hFFFD_0000, 32'h0001_0000, 32'h0002_0000, 32'h0001_0000, 32'h0007_0000, 32'h0000_C000};
    sv[3] = '{32'h4000_0000, 32'h4000_0000, 32'h0, 32'h0001_0000, 32'h0001_0000, 32'h0};
    for (int k = 0; k < 4; k++) begin
      send(sv[k][0], sv[k][1], sv[k][2], sv[k][3], sv[k][4], sv[k][5]);
      acc_t[k] = last_acc;
    end
    wait_result(r, o, lat);
    @(posedge clk); #1;
    @(negedge clk);
    for (int k = 1; k < 4; k++) chk("stream_ii", acc_t[k] - acc_t[k-1], 32'd5);
    chk("stream_count", dut_log.size(), 32'd4);
    for (int k = 0; k < 4 && k < dut_log.size(); k++) begin
      e = dot_ref(sv[k][0], sv[k][1], sv[k][2], sv[k][3], sv[k][4], sv[k][5]);
      chk("stream_result", dut_log[k][31:0], e[31:0]);
      chk("stream_ovf", {31'd0, dut_log[k][32]}, {31'd0, e[32]});
    end
    if (dut_log.size() > 0) chk("stream_first_lit", dut_log[0][31:0], 32'hFFFF_8000);
    if (dut_log.size() > 3) chk("stream_last_ovf", {31'd0, dut_log[3][32]}, 32'd1);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
